idct8x8_top: RTL and testbench
==============================

// Module: idct8x8_top
// PURPOSE
//  Sequential 8x8 2-D inverse DCT (JPEG-style, no level shift), row-column decomposition,
//  one multiply-accumulate per clock. Takes a 64-coefficient block, returns 64 clamped
//  8-bit pixels. Top of the decoder's IDCT stage; coefficients from dequantiser, pixels to writer.
// PARAMETERS
//  COEF_W  16  signed input coefficient width
//  ACC_W   32  signed intermediate/accumulator width (row_data_out, col_data_out)
//  FRAC    12  fractional bits of cosine ROM (Q12) and rounding shift per pass
// PORTS
//  sys_clk    in   1          single clock, rising edge
//  sys_rst    in   1          synchronous, active-low reset
//  start      in   1          1-cycle request; sampled only in IDLE
//  x          in   16x[8][8]  signed coefficients x[u][v], u=row(vertical freq), v=col
//  done       out  1          high while result valid (DONE state)
//  pixel_out  out  8x[8][8]   unsigned pixels pixel_out[row][col]
//  Debug-visible internals (hierarchical names fixed): state[1:0], row_data_out[8][8],
//  col_data_out[8][8] (signed ACC_W), row_count, col_count, r_element, i, j (4 bit each).
// BEHAVIOUR
//  Reset (sys_rst==0 at clk edge): state=IDLE; done=0; pixel_out, row/col_data_out, counters=0.
//  Cosine ROM c[k][n] = round(4096 * C(k)/2 * cos((2n+1)k*pi/16)), C(0)=1/sqrt2 else 1; signed 16b.
//  FSM (2 bits): IDLE=0, ROW=1, COL=2, DONE=3.
//   IDLE: on start=1 latch x into internal buffer, clear counters -> ROW.
//   ROW : row_data_out[r][n] = rnd(sum_k xbuf[r][k]*c[k][n]); row_count=r, i=r, j=n,
//         r_element=k. 8 cycles per output, 64 outputs = 512 cycles -> COL.
//   COL : col_data_out[m][n] = rnd(sum_k row_data_out[k][n]*c[k][m]); col_count=n, i=m, j=n,
//         r_element=k. 512 cycles. On last cycle pixel_out[m][n] loaded for all 64 -> DONE.
//         (pixel_out may also be written per element; all 64 valid when done rises.)
//   DONE: done=1, pixel_out held stable; start=1 -> relatch x, done=0 -> ROW.
//  rnd(a) = (a + 2048) >>> 12 (arithmetic, round-half-up); product 16x16 into 32-bit accumulate.
//  Pixel = clamp(col_data_out, 0, 255): negative -> 0, >255 -> 255.
//  Latency: done rises on the 1025th rising edge after the edge sampling start (1024 MAC
//  cycles + 1). start while ROW/COL ignored; x changes after latch ignored.
//  Reset mid-operation aborts immediately to IDLE with reset values.
//  Counter wrap: r_element 0..7, j 0..7, i 0..7; all 4-bit, never exceed 7.
// STRUCTURE
//  Package idct_pkg: state enum (IDLE/ROW/COL/DONE), COEF_W/ACC_W/FRAC, 8x8 cosine ROM
//  constant, rounding/clamp functions.
//  One sub-module: idct_mac (signed 16x16 multiply, 32-bit accumulate, clear, round output).
//  Top holds FSM, counters, input buffer, row/col storage, clamp, output register.
// TESTING
//  DC: x[0][0]=1024, else 0, start pulse -> done after 1025 edges; all pixel_out=128.
//  x[0][4]=1024 only -> every row 128,0,0,128,128,0,0,128 (negatives clamped to 0);
//    row_data_out[0][*]=+-362.
//  Clamp: x[0][0]=4096 -> all 255; x[0][0]=-1024 -> all 0.
//  All-zero block -> all 0, done=1; second start in DONE recomputes with new x, done drops.
//  Reset (sys_rst=0) during COL -> state=0, done=0, pixel_out=0 next edge; start while
//    busy ignored (latency unchanged).
//  x[0][4]=x[4][0]=1024 -> pixels in {0,255}: 255 where (row,col) both in {0,3,4,7}.

Source files
------------

// File: rtl/idct_pkg.sv
// Shared types, widths, cosine ROM and arithmetic helpers for the 8x8 IDCT stage.
package idct_pkg;

  localparam int COEF_W = 16;  // signed input coefficient width
  localparam int ACC_W  = 32;  // signed intermediate / accumulator width
  localparam int FRAC   = 12;  // Q12 cosine ROM, rounding shift per pass

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ROW  = 2'd1,
    COL  = 2'd2,
    DONE = 2'd3
  } state_t;

  // c[k][n] = round(4096 * C(k)/2 * cos((2n+1)k*pi/16)), C(0) = 1/sqrt(2)
  localparam logic signed [COEF_W-1:0] COS_ROM [8][8] = '{
    '{ 16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448,  16'sd1448},
    '{ 16'sd2009,  16'sd1703,  16'sd1138,  16'sd400,  -16'sd400,  -16'sd1138, -16'sd1703, -16'sd2009},
    '{ 16'sd1892,  16'sd784,  -16'sd784,  -16'sd1892, -16'sd1892, -16'sd784,   16'sd784,   16'sd1892},
    '{ 16'sd1703, -16'sd400,  -16'sd2009, -16'sd1138,  16'sd1138,  16'sd2009,  16'sd400,  -16'sd1703},
    '{ 16'sd1448, -16'sd1448, -16'sd1448,  16'sd1448,  16'sd1448, -16'sd1448, -16'sd1448,  16'sd1448},
    '{ 16'sd1138, -16'sd2009,  16'sd400,   16'sd1703, -16'sd1703, -16'sd400,   16'sd2009, -16'sd1138},
    '{ 16'sd784,  -16'sd1892,  16'sd1892, -16'sd784,  -16'sd784,   16'sd1892, -16'sd1892,  16'sd784},
    '{ 16'sd400,  -16'sd1138,  16'sd1703, -16'sd2009,  16'sd2009, -16'sd1703,  16'sd1138, -16'sd400}
  };

  localparam logic signed [ACC_W-1:0] RND_HALF = ACC_W'(1 << (FRAC - 1));

  // Round-half-up and drop the Q12 fraction.
  function automatic logic signed [ACC_W-1:0] rnd(input logic signed [ACC_W-1:0] a);
    return (a + RND_HALF) >>> FRAC;
  endfunction

  // Saturate a signed sample into the unsigned 8-bit pixel range.
  function automatic logic [7:0] clamp8(input logic signed [ACC_W-1:0] a);
    if (a < 0)        return 8'd0;
    else if (a > 255) return 8'hFF;
    else              return a[7:0];
  endfunction

endpackage

// File: rtl/idct_mac.sv
// Signed multiply-accumulate with synchronous clear; exposes the rounded running sum.
module idct_mac
  import idct_pkg::*;
#(
  parameter int A_W = 32,
  parameter int B_W = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    en_i,
  input  logic                    clr_i,
  input  logic signed [A_W-1:0]   a_i,
  input  logic signed [B_W-1:0]   b_i,
  output logic signed [ACC_W-1:0] rnd_o
);

  logic signed [A_W+B_W-1:0] prod;
  logic signed [ACC_W-1:0]   acc_q, acc_d;

  // Product plus (optionally cleared) accumulator; rounded value is ready in the same cycle.
  always_comb begin
    prod  = (A_W+B_W)'(a_i) * (A_W+B_W)'(b_i);
    acc_d = (clr_i ? '0 : acc_q) + $signed(prod[ACC_W-1:0]);
    rnd_o = rnd(acc_d);
  end

  // Accumulator register.
  always_ff @(posedge clk_i) begin
    if (!rst_ni)   acc_q <= '0;
    else if (en_i) acc_q <= acc_d;
  end

endmodule

// File: rtl/idct8x8_top.sv
// Sequential 8x8 2-D IDCT: row pass then column pass, one MAC per clock, clamped 8-bit output.
module idct8x8_top
  import idct_pkg::*;
(
  input  logic                     sys_clk,
  input  logic                     sys_rst,
  input  logic                     start,
  input  logic signed [COEF_W-1:0] x [8][8],
  output logic                     done,
  output logic [7:0]               pixel_out [8][8]
);

  state_t state, state_d;

  logic signed [COEF_W-1:0] xbuf_q       [8][8];
  logic signed [ACC_W-1:0]  row_data_out [8][8];
  logic signed [ACC_W-1:0]  col_data_out [8][8];
  logic [3:0] row_count, col_count, r_element, i, j;
  logic [3:0] k_d, i_d, j_d;
  logic       last_k, last_elem, mac_en, mac_clr;
  logic signed [ACC_W-1:0]  mac_a, mac_rnd;
  logic signed [COEF_W-1:0] mac_b;

  assign last_k    = (r_element == 4'd7);
  assign last_elem = last_k && (i == 4'd7) && (j == 4'd7);

  // State register.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) state <= IDLE;
    else          state <= state_d;
  end

  // Next-state logic.
  always_comb begin
    state_d = state;
    case (state)
      IDLE:    if (start)     state_d = ROW;
      ROW:     if (last_elem) state_d = COL;
      COL:     if (last_elem) state_d = DONE;
      DONE:    if (start)     state_d = ROW;
      default:                state_d = IDLE;
    endcase
  end

  // MAC control and operand selection per pass.
  always_comb begin
    mac_en  = (state == ROW) || (state == COL);
    mac_clr = (r_element == 4'd0);
    if (state == COL) begin
      mac_a = row_data_out[r_element[2:0]][j[2:0]];
      mac_b = COS_ROM[r_element[2:0]][i[2:0]];
    end else begin
      mac_a = ACC_W'(xbuf_q[i[2:0]][r_element[2:0]]);
      mac_b = COS_ROM[r_element[2:0]][j[2:0]];
    end
  end

  // Counter advance: row pass walks n (j) fastest, column pass walks m (i) fastest.
  always_comb begin
    k_d = last_k ? '0 : r_element + 4'd1;
    i_d = i;
    j_d = j;
    if (last_k) begin
      if (state == ROW) begin
        if (j == 4'd7) begin
          j_d = '0;
          i_d = (i == 4'd7) ? '0 : i + 4'd1;
        end else begin
          j_d = j + 4'd1;
        end
      end else begin
        if (i == 4'd7) begin
          i_d = '0;
          j_d = (j == 4'd7) ? '0 : j + 4'd1;
        end else begin
          i_d = i + 4'd1;
        end
      end
    end
  end

  // Datapath: input latch, counters, row/column storage, pixel output, done flag.
  always_ff @(posedge sys_clk) begin
    if (!sys_rst) begin
      done      <= 1'b0;
      row_count <= '0;
      col_count <= '0;
      r_element <= '0;
      i         <= '0;
      j         <= '0;
      for (int unsigned r = 0; r < 8; r++) begin
        for (int unsigned c = 0; c < 8; c++) begin
          xbuf_q[r][c]       <= '0;
          row_data_out[r][c] <= '0;
          col_data_out[r][c] <= '0;
          pixel_out[r][c]    <= '0;
        end
      end
    end else begin
      case (state)
        IDLE, DONE: begin
          // done follows DONE one edge late so it marks a fully settled pixel array
          done <= (state == DONE) && !start;
          if (start) begin
            xbuf_q    <= x;
            r_element <= '0;
            i         <= '0;
            j         <= '0;
            row_count <= '0;
            col_count <= '0;
          end
        end
        ROW: begin
          r_element <= k_d;
          i         <= i_d;
          j         <= j_d;
          row_count <= i_d;
          if (last_k) row_data_out[i[2:0]][j[2:0]] <= mac_rnd;
        end
        COL: begin
          r_element <= k_d;
          i         <= i_d;
          j         <= j_d;
          col_count <= j_d;
          if (last_k) begin
            col_data_out[i[2:0]][j[2:0]] <= mac_rnd;
            pixel_out[i[2:0]][j[2:0]]    <= clamp8(mac_rnd);
          end
        end
        default: done <= 1'b0;
      endcase
    end
  end

  idct_mac #(
    .A_W (ACC_W),
    .B_W (COEF_W)
  ) u_mac (
    .clk_i  (sys_clk),
    .rst_ni (sys_rst),
    .en_i   (mac_en),
    .clr_i  (mac_clr),
    .a_i    (mac_a),
    .b_i    (mac_b),
    .rnd_o  (mac_rnd)
  );

endmodule

// File: tb/tb_idct8x8_top.sv
// Self-checking bench for idct8x8_top against a floating-point-derived integer IDCT model.
module tb_idct8x8_top;

  logic              sys_clk = 1'b0;
  logic              sys_rst = 1'b0;
  logic              start   = 1'b0;
  logic signed [15:0] x [8][8];
  logic              done;
  logic [7:0]        pixel_out [8][8];

  int     tests = 0;
  int     fails = 0;
  longint cm   [8][8];
  longint xm   [8][8];
  longint rowm [8][8];
  int     pixm [8][8];

  idct8x8_top dut (
    .sys_clk   (sys_clk),
    .sys_rst   (sys_rst),
    .start     (start),
    .x         (x),
    .done      (done),
    .pixel_out (pixel_out)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check(input string tag, input longint got, input longint exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic bit in_s(input int v);
    return (v == 0) || (v == 3) || (v == 4) || (v == 7);
  endfunction

  // Cosine table derived directly from the closed-form definition.
  function automatic void build_rom();
    real pi, ck, v;
    pi = 3.14159265358979323846;
    for (int k = 0; k < 8; k++)
      for (int n = 0; n < 8; n++) begin
        ck = (k == 0) ? 1.0 / $sqrt(2.0) : 1.0;
        v  = 4096.0 * ck / 2.0 * $cos(real'((2 * n + 1) * k) * pi / 16.0);
        cm[k][n] = (v >= 0.0) ? longint'($rtoi(v + 0.5)) : -longint'($rtoi(-v + 0.5));
      end
  endfunction

  // Two separable passes with round-half-up, then clamp to 0..255.
  function automatic void model();
    longint s;
    for (int r = 0; r < 8; r++)
      for (int n = 0; n < 8; n++) begin
        s = 0;
        for (int k = 0; k < 8; k++) s += xm[r][k] * cm[k][n];
        rowm[r][n] = (s + 2048) >>> 12;
      end
    for (int m = 0; m < 8; m++)
      for (int n = 0; n < 8; n++) begin
        s = 0;
        for (int k = 0; k < 8; k++) s += rowm[k][n] * cm[k][m];
        s = (s + 2048) >>> 12;
        pixm[m][n] = (s < 0) ? 0 : (s > 255) ? 255 : int'(s);
      end
  endfunction

  task automatic clear_x();
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) x[r][c] = '0;
  endtask

  task automatic rand_x();
    int v;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) begin
        v = int'($urandom_range(0, 511)) - 256;
        x[r][c] = 16'(v);
      end
    v = int'($urandom_range(0, 4095)) - 2048;
    x[0][0] = 16'(v);
  endtask

  // Launch one block from the current x; optionally poke start and scramble x while busy.
  task automatic launch(input bit poke);
    int cnt;
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++) xm[r][c] = longint'(x[r][c]);
    model();
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    check("done_drop", done, 0);
    cnt = 0;
    while (!done && cnt < 1100) begin
      @(posedge sys_clk); #1;
      cnt++;
      if (poke && (cnt == 300 || cnt == 700)) begin
        start = 1'b1;
        rand_x();
      end
      if (poke && (cnt == 301 || cnt == 701)) start = 1'b0;
    end
    check("latency", cnt, 1025);
    for (int m = 0; m < 8; m++)
      for (int n = 0; n < 8; n++)
        check($sformatf("pix[%0d][%0d]", m, n), pixel_out[m][n], pixm[m][n]);
  endtask

  initial begin
    build_rom();
    clear_x();
    repeat (2) @(posedge sys_clk);
    #1;
    check("rst_state", longint'(dut.state), 0);
    check("rst_done", done, 0);
    check("rst_pix", pixel_out[3][5], 0);
    check("rst_row", dut.row_data_out[0][0], 0);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;

    // DC only
    x[0][0] = 16'sd1024;
    launch(1'b0);
    for (int r = 0; r < 8; r++) check("dc128", pixel_out[r][7 - r], 128);

    // Single horizontal frequency 4
    clear_x();
    x[0][4] = 16'sd1024;
    launch(1'b0);
    for (int n = 0; n < 8; n++) begin
      check("row362", dut.row_data_out[0][n], in_s(n) ? 362 : -362);
      check("x04pix", pixel_out[5][n], in_s(n) ? 128 : 0);
    end

    // Saturation both ways
    clear_x();
    x[0][0] = 16'sd4096;
    launch(1'b0);
    check("sat255", pixel_out[6][1], 255);
    x[0][0] = -16'sd1024;
    launch(1'b0);
    check("sat0", pixel_out[2][2], 0);

    // All-zero block, then hold in DONE
    clear_x();
    launch(1'b0);
    repeat (3) @(posedge sys_clk);
    #1;
    check("hold_done", done, 1);
    check("hold_state", longint'(dut.state), 3);

    // Two-frequency checkerboard
    x[0][4] = 16'sd1024;
    x[4][0] = 16'sd1024;
    launch(1'b0);
    for (int r = 0; r < 8; r++)
      for (int c = 0; c < 8; c++)
        check("x04x40", pixel_out[r][c], (in_s(r) && in_s(c)) ? 255 : 0);

    // Random blocks, with ignored start pulses and x changes while busy
    for (int t = 0; t < 4; t++) begin
      rand_x();
      launch(t[0]);
    end

    // Reset during the column pass
    clear_x();
    x[0][0] = 16'sd1024;
    start = 1'b1;
    @(posedge sys_clk); #1;
    start = 1'b0;
    repeat (700) @(posedge sys_clk);
    #1;
    check("in_col", longint'(dut.state), 2);
    sys_rst = 1'b0;
    @(posedge sys_clk); #1;
    check("abort_state", longint'(dut.state), 0);
    check("abort_done", done, 0);
    check("abort_pix", pixel_out[0][0], 0);
    check("abort_i", dut.i, 0);
    sys_rst = 1'b1;
    @(posedge sys_clk); #1;

    rand_x();
    launch(1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
